// File: rtl/titan_spi_host.sv
// Host-side SPI initiator for the Titan command interface: serializes an
// 8-byte command frame (mode 0, MSB first) and captures up to 4 response bytes.
module titan_spi_host #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [7:0]  cmd_instruction_i,
  input  logic [23:0] cmd_address_i,
  input  logic [31:0] cmd_value_i,
  input  logic [2:0]  cmd_rsp_bytes_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_data_o,
  output logic        busy_o,
  output logic        sclk_o,
  output logic        pico_o,
  input  logic        poci_i,
  output logic        cs_n_o
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int GW = $clog2(CS_GAP + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

  state_t        state, state_d;
  logic [DW-1:0] div_cnt;
  logic [GW-1:0] gap_cnt;
  logic [6:0]    bit_cnt;
  logic [6:0]    last_bit;
  logic [63:0]   tx;
  logic [31:0]   cap;
  logic [2:0]    rsp_bytes;
  logic          accept, div_done, gap_done, last_done;

  assign rsp_bytes   = (cmd_rsp_bytes_i > 3'd4) ? 3'd4 : cmd_rsp_bytes_i;
  assign accept      = cmd_valid_i && (state == IDLE);
  assign div_done    = (div_cnt == DIV_LAST);
  assign gap_done    = (gap_cnt == GAP_LAST);
  assign last_done   = div_done && sclk_o && (bit_cnt == last_bit);
  assign cmd_ready_o = (state == IDLE);
  assign busy_o      = (state != IDLE);

  always_ff @(posedge clk_i) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:  if (accept)    state_d = SHIFT;
      SHIFT: if (last_done) state_d = HOLD;
      HOLD:  if (div_done)  state_d = GAP;
      GAP:   if (gap_done)  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      gap_cnt     <= '0;
      bit_cnt     <= '0;
      last_bit    <= '0;
      tx          <= '0;
      cap         <= '0;
      sclk_o      <= 1'b0;
      pico_o      <= 1'b0;
      cs_n_o      <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
    end else begin
      rsp_valid_o <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          tx       <= {cmd_instruction_i, cmd_address_i, cmd_value_i};
          pico_o   <= cmd_instruction_i[7];
          cs_n_o   <= 1'b0;
          sclk_o   <= 1'b0;
          div_cnt  <= '0;
          bit_cnt  <= '0;
          cap      <= '0;
          last_bit <= 7'd63 + {1'b0, rsp_bytes, 3'b000};
        end
        SHIFT: begin
          div_cnt <= div_done ? '0 : div_cnt + 1'b1;
          if (div_done) begin
            if (!sclk_o) begin
              sclk_o <= 1'b1;
              // Only response bytes (bit index >= 64) land in the capture register
              if (bit_cnt[6]) cap <= {cap[30:0], poci_i};
            end else begin
              sclk_o <= 1'b0;
              if (bit_cnt == last_bit) begin
                pico_o <= 1'b0;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                tx      <= {tx[62:0], 1'b0};
                pico_o  <= tx[62];
              end
            end
          end
        end
        HOLD: begin
          div_cnt <= div_done ? '0 : div_cnt + 1'b1;
          if (div_done) begin
            cs_n_o      <= 1'b1;
            rsp_valid_o <= 1'b1;
            rsp_data_o  <= cap;
            gap_cnt     <= '0;
          end
        end
        GAP: gap_cnt <= gap_cnt + 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_titan_spi_host.sv
// Directed bench for titan_spi_host: table of frames checked against a
// behavioural SPI responder, plus back-to-back and mid-frame reset sequences.
module tb_titan_spi_host;

  localparam int CLK_DIV = 2;
  localparam int CS_GAP  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_instruction;
  logic [23:0] cmd_address;
  logic [31:0] cmd_value;
  logic [2:0]  cmd_rsp_bytes;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        busy, sclk, pico, poci, cs_n;

  titan_spi_host #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
    .clk_i(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_instruction_i(cmd_instruction), .cmd_address_i(cmd_address),
    .cmd_value_i(cmd_value), .cmd_rsp_bytes_i(cmd_rsp_bytes),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .busy_o(busy),
    .sclk_o(sclk), .pico_o(pico), .poci_i(poci), .cs_n_o(cs_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  instr;
    logic [23:0] addr;
    logic [31:0] value;
    logic [2:0]  rsp;
    logic [31:0] resp;      // word the responder returns
    int          reff;      // response bytes the responder drives
    logic [31:0] exp_data;
    int          exp_edges;
    int          exp_lat;
    logic [95:0] exp_rx;
  } vec_t;

  vec_t vecs[5];
  int   checks = 0;
  int   failures = 0;

  // Responder model: records PICO on each SCLK rise, shifts POCI after it
  int          bitcnt = 0;
  logic [95:0] rx = '0;
  logic [31:0] resp_word = '0;
  int          reff = 0;
  int          pj;

  always @(negedge cs_n or posedge sclk) begin
    if (sclk) begin
      rx = {rx[94:0], pico};
      bitcnt++;
    end else begin
      rx = '0;
      bitcnt = 0;
    end
  end

  always_comb begin
    poci = 1'b0;
    pj = bitcnt - 64;
    if (!cs_n && bitcnt >= 64 && pj < 8 * reff)
      poci = resp_word[5'(8 * reff - 1 - pj)];
  end

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic set_cmd(input int i);
    cmd_instruction = vecs[i].instr;
    cmd_address     = vecs[i].addr;
    cmd_value       = vecs[i].value;
    cmd_rsp_bytes   = vecs[i].rsp;
    resp_word       = vecs[i].resp;
    reff            = vecs[i].reff;
  endtask

  task automatic wait_rsp(input int start, output int lat);
    int k = start;
    while (!rsp_valid && k < 3000) begin
      @(negedge clk);
      k++;
    end
    lat = k;
  endtask

  task automatic check_frame(input int i, input int lat);
    check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
    check($sformatf("v%0d_sclk_edges", i), bitcnt, vecs[i].exp_edges);
    check($sformatf("v%0d_rsp_data", i), rsp_data, vecs[i].exp_data);
    check($sformatf("v%0d_pico_frame", i), rx, vecs[i].exp_rx);
  endtask

  task automatic run_vec(input int i);
    int n = 0;
    int lat;
    set_cmd(i);
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("v%0d_ready", i), cmd_ready, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check($sformatf("v%0d_cs_low", i), cs_n, 1'b0);
    wait_rsp(1, lat);
    check_frame(i, lat);
    @(negedge clk);
    check($sformatf("v%0d_pulse_width", i), rsp_valid, 1'b0);
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("v%0d_idle", i), {busy, cmd_ready, cs_n}, 3'b011);
    check($sformatf("v%0d_data_hold", i), rsp_data, vecs[i].exp_data);
  endtask

  initial begin
    int lat, gap, n, pulses;
    vecs[0] = '{8'h01, 24'h000002, 32'hDEADBEEF, 3'd0, 32'h0, 0, 32'h0,
                64, 259, 96'h0000_0000_0100_0002_DEAD_BEEF};
    vecs[1] = '{8'h02, 24'h000001, 32'h0, 3'd4, 32'h12345678, 4, 32'h12345678,
                96, 387, 96'h0200_0001_0000_0000_0000_0000};
    vecs[2] = '{8'h03, 24'hABCDEF, 32'h01020304, 3'd2, 32'h0000A55A, 2, 32'h0000A55A,
                80, 323, 96'h0000_03AB_CDEF_0102_0304_0000};
    vecs[3] = '{8'h04, 24'h123456, 32'hCAFEF00D, 3'd7, 32'h89ABCDEF, 4, 32'h89ABCDEF,
                96, 387, 96'h0412_3456_CAFE_F00D_0000_0000};
    vecs[4] = '{8'h05, 24'h000010, 32'h55AA55AA, 3'd1, 32'h0000003C, 1, 32'h0000003C,
                72, 291, 96'h0000_0005_0000_1055_AA55_AA00};

    rst_n = 1'b0;
    cmd_valid = 1'b0;
    set_cmd(0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_outputs", {cs_n, sclk, pico, rsp_valid, busy, cmd_ready}, 6'b100001);
    check("reset_rsp_data", rsp_data, 32'h0);

    // Order puts an R=0 frame after a read so a stale result would show
    run_vec(1);
    run_vec(2);
    run_vec(0);
    run_vec(3);
    run_vec(4);

    // Back-to-back with cmd_valid held, inputs changed and toggled mid-frame
    set_cmd(0);
    cmd_valid = 1'b1;
    @(negedge clk);
    lat = 1;
    while (!rsp_valid && lat < 3000) begin
      @(negedge clk);
      lat++;
      if (lat == 40) begin set_cmd(2); cmd_valid = 1'b0; end
      if (lat == 41) cmd_valid = 1'b1;
      if (lat == 43) cmd_valid = 1'b0;
      if (lat == 60) cmd_valid = 1'b1;
    end
    check_frame(0, lat);
    gap = 1;
    @(negedge clk);
    while (cs_n && gap < 50) begin
      gap++;
      @(negedge clk);
    end
    check("b2b_cs_high_cycles", gap, CS_GAP + 1);
    cmd_valid = 1'b0;
    wait_rsp(1, lat);
    check_frame(2, lat);

    // Reset during byte 3 of a read frame
    n = 0;
    while (busy && n < 50) begin @(negedge clk); n++; end
    set_cmd(1);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (bitcnt < 26 && n < 2000) begin @(negedge clk); n++; end
    check("midreset_reached_byte3", bitcnt, 26);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_outputs", {cs_n, sclk, pico, rsp_valid, busy}, 5'b10000);
    rst_n = 1'b1;
    pulses = 0;
    repeat (500) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    check("midreset_no_rsp", pulses, 0);
    check("midreset_rsp_data", rsp_data, 32'h0);
    run_vec(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
